// File: rtl/repl_pkg.sv
// Shared definitions for the FIFO replacement controller: way geometry,
// FIFO counter width and the controller state encoding.
package repl_pkg;

    localparam int unsigned NUM_WAYS = 8;
    localparam int unsigned CTR_W    = 3;
    localparam int unsigned WAY_W    = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SELECT    = 2'd1,
        WAIT_FILL = 2'd2,
        UPDATE    = 2'd3
    } state_e;

endpackage : repl_pkg

// File: rtl/repl_ctr_cell.sv
// One FIFO age counter for a single way of a single set. A value of 0 marks
// the oldest way and 7 the most recently filled. Load makes the way the
// youngest; dec ages it by one step toward eviction.
module repl_ctr_cell
    import repl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [CTR_W-1:0] init_val_i,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [CTR_W-1:0] cnt_o
);

    logic [CTR_W-1:0] cnt_q;
    logic [CTR_W-1:0] cnt_d;

    // Next age: load wins over dec, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '1;
        end else if (dec_i) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Age register, reset to the way's own index.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= init_val_i;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : repl_ctr_cell

// File: rtl/fifo_repl_ctrl.sv
// FIFO replacement controller for an 8-way cache. On a miss it picks the
// lowest invalid way of the set, or else the oldest way (counter 0), holds the
// choice while the line is filled, then makes that way the youngest and ages
// the ways that were younger than it, keeping each set a permutation of 0..7.
module fifo_repl_ctrl
    import repl_pkg::*;
#(
    parameter  int unsigned NUM_SETS = 4,
    localparam int unsigned SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             miss_req,
    input  logic [SET_W-1:0] miss_set,
    input  logic             fill_done,
    input  logic             inv_req,
    input  logic [SET_W-1:0] inv_set,
    input  logic [WAY_W-1:0] inv_way,
    output logic             victim_vld,
    output logic [WAY_W-1:0] victim_way,
    output logic             victim_dirty_evict,
    output logic             miss_ack,
    output logic             busy
);

    state_e state_q;
    state_e state_d;

    logic [SET_W-1:0] set_q;
    logic [WAY_W-1:0] vway_q;
    logic [CTR_W-1:0] vctr_q;
    logic             vdirty_q;

    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_d;

    logic [CTR_W-1:0] ctr_w [NUM_SETS][NUM_WAYS];

    logic [WAY_W-1:0] sel_way;
    logic [CTR_W-1:0] sel_ctr;
    logic             sel_dirty;
    logic             sel_hit;

    // Counter array: one cell per way per set, driven only while in UPDATE.
    for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
        for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
            logic             hit;
            logic             ld;
            logic             dc;
            logic [CTR_W-1:0] cnt;

            assign hit = (state_q == UPDATE) && (set_q == SET_W'(s));
            assign ld  = hit && (vway_q == WAY_W'(w));
            assign dc  = hit && !ld && (cnt > vctr_q);

            repl_ctr_cell u_cell (
                .clk        (clk),
                .reset      (reset),
                .init_val_i (CTR_W'(w)),
                .load_i     (ld),
                .dec_i      (dc),
                .cnt_o      (cnt)
            );

            assign ctr_w[s][w] = cnt;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one miss in flight, extra requests are dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (miss_req) state_d = SELECT;
            SELECT:    state_d = WAIT_FILL;
            WAIT_FILL: if (fill_done) state_d = UPDATE;
            UPDATE:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs: victim info is only exposed while the fill is pending.
    always_comb begin
        victim_vld         = 1'b0;
        victim_way         = '0;
        victim_dirty_evict = 1'b0;
        miss_ack           = 1'b0;
        busy               = (state_q != IDLE);
        case (state_q)
            WAIT_FILL: begin
                victim_vld         = 1'b1;
                victim_way         = vway_q;
                victim_dirty_evict = vdirty_q;
            end
            UPDATE:  miss_ack = 1'b1;
            default: ;
        endcase
    end

    // Victim choice: first invalid way, else the way whose age is 0.
    always_comb begin
        sel_way = '0;
        sel_hit = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            if (!sel_hit && !valid_q[set_q][WAY_W'(w)]) begin
                sel_way = WAY_W'(w);
                sel_hit = 1'b1;
            end
        end
        if (!sel_hit) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                if (ctr_w[set_q][WAY_W'(w)] == '0) begin
                    sel_way = WAY_W'(w);
                end
            end
        end
        sel_ctr   = ctr_w[set_q][sel_way];
        sel_dirty = valid_q[set_q][sel_way];
    end

    // Miss context: set latched on acceptance, victim latched in SELECT.
    always_ff @(posedge clk) begin
        if (reset) begin
            set_q    <= '0;
            vway_q   <= '0;
            vctr_q   <= '0;
            vdirty_q <= 1'b0;
        end else begin
            if (state_q == IDLE && miss_req) begin
                set_q <= miss_set;
            end
            if (state_q == SELECT) begin
                vway_q   <= sel_way;
                vctr_q   <= sel_ctr;
                vdirty_q <= sel_dirty;
            end
        end
    end

    // Valid next state: the UPDATE write is applied after the invalidate so a
    // same-way collision leaves the line valid.
    always_comb begin
        valid_d = valid_q;
        if (inv_req) begin
            valid_d[inv_set][inv_way] = 1'b0;
        end
        if (state_q == UPDATE) begin
            valid_d[set_q][vway_q] = 1'b1;
        end
    end

    // Valid bit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule : fifo_repl_ctrl

// File: tb/tb_fifo_repl_ctrl.sv
// Directed bench for fifo_repl_ctrl: a table of miss transactions with
// hand-computed victims and counter snapshots, plus hand-written sequences
// for invalidate collisions, request filtering, latency and mid-fill reset.
module tb_fifo_repl_ctrl;
    import repl_pkg::*;

    localparam int unsigned NS = 4;
    localparam logic [7:0][2:0] ID  = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [7:0][2:0] C_B = {3'd6, 3'd5, 3'd7, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [7:0][2:0] C_C = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5};
    localparam logic [7:0][2:0] C_S0 = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};

    logic       clk;
    logic       reset;
    logic       miss_req;
    logic [1:0] miss_set;
    logic       fill_done;
    logic       inv_req;
    logic [1:0] inv_set;
    logic [2:0] inv_way;
    logic       victim_vld;
    logic [2:0] victim_way;
    logic       victim_dirty_evict;
    logic       miss_ack;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    fifo_repl_ctrl #(.NUM_SETS(NS)) dut (
        .clk                (clk),
        .reset              (reset),
        .miss_req           (miss_req),
        .miss_set           (miss_set),
        .fill_done          (fill_done),
        .inv_req            (inv_req),
        .inv_set            (inv_set),
        .inv_way            (inv_way),
        .victim_vld         (victim_vld),
        .victim_way         (victim_way),
        .victim_dirty_evict (victim_dirty_evict),
        .miss_ack           (miss_ack),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct {
        bit              rst;
        bit              inv;
        logic [2:0]      inv_way;
        logic [1:0]      set;
        logic [2:0]      exp_way;
        bit              exp_dirty;
        bit              chk_ctr;
        logic [7:0][2:0] exp_ctr;
    } vec_t;

    vec_t vt [25];

    function automatic vec_t mk(bit rst, bit inv, int iw, int s, int ew, bit ed,
                                bit cc, logic [7:0][2:0] ec);
        vec_t v;
        v.rst       = rst;
        v.inv       = inv;
        v.inv_way   = 3'(iw);
        v.set       = 2'(s);
        v.exp_way   = 3'(ew);
        v.exp_dirty = ed;
        v.chk_ctr   = cc;
        v.exp_ctr   = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_set(input string tag, input logic [1:0] s, input logic [7:0][2:0] exp);
        logic [7:0] seen;
        seen = '0;
        for (int w = 0; w < 8; w++) begin
            logic [2:0] wi;
            logic [2:0] c;
            wi = 3'(w);
            c  = dut.ctr_w[s][wi];
            chk($sformatf("%s ctr set%0d way%0d", tag, s, w), int'(c), int'(exp[w]));
            seen[c] = 1'b1;
        end
        chk($sformatf("%s permutation set%0d", tag, s), int'(seen), 255);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        miss_req  = 1'b0;
        fill_done = 1'b0;
        inv_req   = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // inv_mode: 0 none, 1 invalidate victim during WAIT_FILL, 2 during UPDATE
    task automatic run_miss(input logic [1:0] s, input int inv_mode,
                            output int way, output int dirty, output int acks);
        int n;
        way   = -1;
        dirty = -1;
        acks  = 0;
        miss_set = s;
        miss_req = 1'b1;
        @(posedge clk); #1;
        miss_req = 1'b0;
        n = 0;
        while (!victim_vld && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (!victim_vld) begin
            chk("victim_vld wait", 0, 1);
            return;
        end
        way   = int'(victim_way);
        dirty = int'(victim_dirty_evict);
        if (inv_mode == 1) begin
            inv_req = 1'b1;
            inv_set = s;
            inv_way = victim_way;
            @(posedge clk); #1;
            inv_req = 1'b0;
            chk("inv during fill clears valid", int'(dut.valid_q[s][inv_way]), 0);
            chk("victim_way stable after inv", int'(victim_way), way);
        end
        fill_done = 1'b1;
        @(posedge clk); #1;
        fill_done = 1'b0;
        if (inv_mode == 2) begin
            inv_req = 1'b1;
            inv_set = s;
            inv_way = 3'(way);
        end
        repeat (4) begin
            if (miss_ack) acks++;
            @(posedge clk); #1;
            inv_req = 1'b0;
        end
    endtask

    initial begin
        int way, dirty, acks, n;
        logic [1:0] si;

        reset = 1'b0; miss_req = 1'b0; miss_set = '0; fill_done = 1'b0;
        inv_req = 1'b0; inv_set = '0; inv_way = '0;

        for (int i = 0; i < 8; i++) vt[i] = mk(i == 0, 0, 0, 0, i, 0, i == 7, ID);
        vt[8] = mk(0, 1, 5, 0, 5, 0, 1, C_B);
        for (int i = 0; i < 8; i++) vt[9 + i] = mk(i == 0, 0, 0, 0, i, 0, 0, ID);
        for (int i = 0; i < 3; i++) vt[17 + i] = mk(0, 0, 0, 0, i, 1, i == 2, C_C);
        vt[20] = mk(1, 0, 0, 1, 0, 0, 0, ID);
        vt[21] = mk(0, 0, 0, 0, 0, 0, 0, ID);
        vt[22] = mk(0, 0, 0, 1, 1, 0, 0, ID);
        vt[23] = mk(0, 0, 0, 0, 1, 0, 1, C_S0);
        vt[24] = mk(0, 0, 0, 1, 2, 0, 1, C_C);

        // Reset state
        do_reset();
        chk("reset victim_vld", int'(victim_vld), 0);
        chk("reset victim_way", int'(victim_way), 0);
        chk("reset dirty_evict", int'(victim_dirty_evict), 0);
        chk("reset miss_ack", int'(miss_ack), 0);
        chk("reset busy", int'(busy), 0);
        for (int s = 0; s < 4; s++) begin
            si = 2'(s);
            chk_set("reset", si, ID);
            chk($sformatf("reset valid set%0d", s), int'(dut.valid_q[si]), 0);
        end

        // Table-driven miss transactions
        for (int i = 0; i < 25; i++) begin
            if (vt[i].rst) do_reset();
            if (vt[i].inv) begin
                inv_req = 1'b1;
                inv_set = vt[i].set;
                inv_way = vt[i].inv_way;
                @(posedge clk); #1;
                inv_req = 1'b0;
            end
            run_miss(vt[i].set, 0, way, dirty, acks);
            chk($sformatf("vec%0d victim_way", i), way, int'(vt[i].exp_way));
            chk($sformatf("vec%0d dirty_evict", i), dirty, int'(vt[i].exp_dirty));
            chk($sformatf("vec%0d miss_ack count", i), acks, 1);
            chk($sformatf("vec%0d busy idle", i), int'(busy), 0);
            if (vt[i].chk_ctr) chk_set($sformatf("vec%0d", i), vt[i].set, vt[i].exp_ctr);
        end
        chk_set("interleave untouched", 2'd2, ID);
        chk_set("interleave untouched", 2'd3, ID);

        // Invalidate collisions on a full set
        do_reset();
        for (int i = 0; i < 8; i++) run_miss(2'd2, 0, way, dirty, acks);
        run_miss(2'd2, 1, way, dirty, acks);
        chk("inv-in-fill victim", way, 0);
        chk("inv-in-fill dirty", dirty, 1);
        chk("inv-in-fill ack", acks, 1);
        chk("inv-in-fill valid after update", int'(dut.valid_q[2][0]), 1);
        run_miss(2'd2, 2, way, dirty, acks);
        chk("inv-in-update victim", way, 1);
        chk("inv-in-update ack", acks, 1);
        chk("inv-in-update valid wins", int'(dut.valid_q[2][1]), 1);

        // Latency and request filtering
        do_reset();
        miss_set = 2'd2;
        miss_req = 1'b1;
        @(posedge clk); #1;
        chk("latency vld at N+1", int'(victim_vld), 0);
        chk("latency busy at N+1", int'(busy), 1);
        miss_set = 2'd3;
        @(posedge clk); #1;
        chk("latency vld at N+2", int'(victim_vld), 1);
        chk("latency victim_way", int'(victim_way), 0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("hold victim_vld", int'(victim_vld), 1);
            chk("hold victim_way", int'(victim_way), 0);
        end
        miss_req  = 1'b0;
        fill_done = 1'b1;
        @(posedge clk); #1;
        fill_done = 1'b0;
        acks = 0;
        repeat (5) begin
            if (miss_ack) acks++;
            @(posedge clk); #1;
        end
        chk("filtered miss_ack count", acks, 1);
        chk("filtered busy", int'(busy), 0);
        chk("filtered set2 way0 ctr", int'(dut.ctr_w[2][0]), 7);
        chk_set("filtered", 2'd3, ID);
        chk("filtered set3 valid", int'(dut.valid_q[3]), 0);

        // Reset during WAIT_FILL
        miss_set = 2'd2;
        miss_req = 1'b1;
        @(posedge clk); #1;
        miss_req = 1'b0;
        n = 0;
        while (!victim_vld && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midfill reached WAIT_FILL", int'(victim_vld), 1);
        chk("midfill victim_way", int'(victim_way), 1);
        reset     = 1'b1;
        fill_done = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midfill busy after reset", int'(busy), 0);
        chk("midfill victim_vld after reset", int'(victim_vld), 0);
        acks = 0;
        repeat (4) begin
            if (miss_ack) acks++;
            @(posedge clk); #1;
            fill_done = 1'b0;
        end
        chk("midfill miss_ack count", acks, 0);
        chk("midfill busy", int'(busy), 0);
        for (int s = 0; s < 4; s++) begin
            si = 2'(s);
            chk_set("midfill", si, ID);
            chk($sformatf("midfill valid set%0d", s), int'(dut.valid_q[si]), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_fifo_repl_ctrl
